csa21_accum_stage: RTL and testbench
====================================

# csa21_accum_stage

Sequential accumulation stage that feeds the existing 21-bit carry-skip adder `UBFCSkA_20_0_20_0` and consumes its 22-bit result. The adder is combinational and computes S = X + Y with a carry-in of 0. This block sums a packet of 21-bit terms arriving over a valid/ready stream. It registers the running sum, tracks a sticky overflow flag and a term count, and presents the packet total on a valid/ready output. It sits between the operand source and downstream result consumers, and gives the carry-skip adder a registered, handshaked context.

## Interface
- `CNT_W`, default 8: width of the term counter; the counter saturates at all-ones.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock, asynchronous and active-low.
- `in_valid`  in  1  input term valid.
- `in_ready`  out  1  stage can accept a term.
- `in_data`  in  21  unsigned term.
- `in_last`  in  1  marks the final term of a packet.
- `out_valid`  out  1  packet total available.
- `out_ready`  in  1  consumer accepts the total.
- `out_sum`  out  21  packet total, modulo 2^21.
- `out_ovf`  out  1  set if any accumulation step in the packet produced adder carry-out S[21]=1.
- `out_cnt`  out  CNT_W  number of terms in the packet, saturating.

## Operation
- **States.**
  - IDLE: accumulator `acc` = 0 and no packet is open.
  - ACCUM: a packet is open.
  - HOLD: a total is being presented.
- **Adder connection.**
  - X = `in_data`.
  - Y = 0 in IDLE and HOLD; Y = `acc` in ACCUM.
  - Adder output S[21:0] is combinational.
- **Handshakes.**
  - Input beat: `in_valid & in_ready`.
  - Output beat: `out_valid & out_ready`.
- **`in_ready`** = `!out_valid | out_ready`.
  - Full throughput.
  - A new packet may start in the same cycle the previous total is taken.
- **On an input beat:**
  - `acc <= S[20:0]`.
  - `ovf <= (ovf_base | S[21])`, where `ovf_base` = 0 if the beat opens a packet (state IDLE, or HOLD with an output beat), else the current `ovf`.
  - `cnt <= (opening ? 1 : sat_inc(cnt))`.
- **On an input beat with `in_last` = 1:**
  - Next state is HOLD.
  - `out_valid <= 1`.
  - `out_sum`, `out_ovf` and `out_cnt` reflect the updated values.
- **On an input beat with `in_last` = 0:** next state is ACCUM.
- **Output beat with no input beat:** next state is IDLE; `acc`, `ovf` and `cnt` clear to 0.
- **HOLD without an output beat:**
  - `in_ready` = 0.
  - All registers and outputs are stable.
- **Single-term packet** (in IDLE, `in_last` = 1): total = `in_data`, ovf = 0, cnt = 1.
- **Width rule.**
  - Internal arithmetic is exactly the 22-bit adder result.
  - Bit 21 is never stored in `acc`; it only sets `ovf`.
- **Saturation.**
  - `cnt` stops at 2^CNT_W-1.
  - `out_cnt` then reads all-ones; accumulation continues.
- **Reset.**
  - Asynchronous; may be asserted mid-packet.
  - State → IDLE; `acc`, `ovf`, `cnt` → 0; `out_valid` → 0.
  - The partial packet is discarded.

## Timing
- Reset values:
  - `out_valid` = 0, `out_sum` = 0, `out_ovf` = 0, `out_cnt` = 0.
  - `in_ready` = 1.
- Latency: `out_valid` rises the cycle after the last term is accepted.
- Throughput: one term per cycle sustained, including across packet boundaries when `out_ready` = 1.
- `out_*` are registered; `in_ready` is combinational from `out_valid`/`out_ready` only.
- Once asserted, `out_valid` and the `out_*` values hold until the output beat completes.
- Critical path: `in_data`/`acc` → carry-skip adder → `acc` D input.

## Structure
- Package `csa21_pkg` holds:
  - `DATA_W` = 21 and `SUM_W` = 22.
  - enum `acc_state_t` {IDLE, ACCUM, HOLD}.
  - function `sat_inc`.
- One sub-module instance: `UBFCSkA_20_0_20_0` (the combinational adder), with X, Y, S wired as above.
- Everything else is a single always_ff/always_comb pair in this block.

## Test plan
- **Three-term packet, no overflow:** terms 5, 7, 9 with `last` on 9, `out_ready` = 1 → `out_sum` = 21, `out_ovf` = 0, `out_cnt` = 3, `out_valid` the cycle after 9.
- **Overflow:** 0x1FFFFF then 0x000002 (last) → `out_sum` = 0x000001, `out_ovf` = 1, `out_cnt` = 2.
- **Back-pressure:** `out_ready` = 0 for 4 cycles after a packet ends → `in_ready` = 0 and outputs stable; on `out_ready` = 1, a waiting term 3 (last) is accepted the same cycle → next `out_sum` = 3, `out_cnt` = 1, `out_ovf` = 0.
- **Reset mid-packet:** terms 100, 200, then `rst_n` low 1 cycle → `out_valid` = 0; a following packet of 10 (last) gives `out_sum` = 10, `out_cnt` = 1.
- **Saturation** (`CNT_W` = 2): 5 terms of 1 → `out_sum` = 5, `out_cnt` = 3.

Source files
------------

// File: rtl/csa21_pkg.sv
// Shared types and helpers for the csa21 accumulation stage.
// Holds operand/result widths, the stage state enum and a saturating increment.
package csa21_pkg;

    localparam int DATA_W = 21;
    localparam int SUM_W  = 22;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } acc_state_t;

    // Increment that sticks at max_v instead of wrapping.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic [31:0] max_v
    );
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/UBFCSkA_20_0_20_0.sv
// 21-bit unsigned carry-skip adder, S = X + Y with carry-in 0.
// Ports: X, Y (21-bit operands), S (22-bit sum, S[21] is carry-out).
module UBFCSkA_20_0_20_0
    import csa21_pkg::*;
(
    input  logic [DATA_W-1:0] X,
    input  logic [DATA_W-1:0] Y,
    output logic [SUM_W-1:0]  S
);

    // Seven 3-bit ripple blocks; a block whose bits all propagate
    // forwards its incoming carry directly instead of its ripple carry.
    localparam int BW = 3;
    localparam int NB = DATA_W / BW;

    logic [DATA_W-1:0] s;
    logic              c;
    logic              cin_blk;
    logic              rc;
    logic              pall;
    logic              p;

    always_comb begin
        s       = '0;
        c       = 1'b0;
        cin_blk = 1'b0;
        rc      = 1'b0;
        pall    = 1'b0;
        p       = 1'b0;
        for (int b = 0; b < NB; b++) begin
            cin_blk = c;
            rc      = c;
            pall    = 1'b1;
            for (int k = 0; k < BW; k++) begin
                p              = X[b*BW+k] ^ Y[b*BW+k];
                s[b*BW+k]      = p ^ rc;
                rc             = (X[b*BW+k] & Y[b*BW+k]) | (p & rc);
                pall           = pall & p;
            end
            c = pall ? cin_blk : rc;
        end
        S = {c, s};
    end

endmodule

// File: rtl/csa21_accum_stage.sv
// Handshaked packet accumulator around the 21-bit carry-skip adder.
// Ports: clk, rst_n; in_valid/in_ready/in_data/in_last term stream;
// out_valid/out_ready/out_sum/out_ovf/out_cnt packet total stream.
module csa21_accum_stage
    import csa21_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  out_cnt
);

    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    acc_state_t        state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] add_y;
    logic [SUM_W-1:0]  add_s;
    logic              in_beat;
    logic              out_beat;
    logic              opening;

    // The stored total doubles as the presented result while in HOLD.
    assign out_valid = (state_q == HOLD);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign out_cnt   = cnt_q;

    assign in_ready = !out_valid | out_ready;
    assign in_beat  = in_valid & in_ready;
    assign out_beat = out_valid & out_ready;

    // A term opens a packet from IDLE, or from HOLD while the old total
    // leaves in the same cycle.
    assign opening = (state_q == IDLE) | ((state_q == HOLD) & out_beat);
    assign add_y   = (state_q == ACCUM) ? acc_q : '0;

    UBFCSkA_20_0_20_0 u_add (
        .X (in_data),
        .Y (add_y),
        .S (add_s)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (in_beat) begin
            acc_d   = add_s[DATA_W-1:0];
            ovf_d   = (opening ? 1'b0 : ovf_q) | add_s[SUM_W-1];
            cnt_d   = opening ? CNT_W'(1)
                              : CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
            state_d = in_last ? HOLD : ACCUM;
        end else if (out_beat) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_csa21_accum_stage.sv
// Directed bench for csa21_accum_stage (CNT_W=8 and CNT_W=2 instances).
// Drives one shared term stream and checks totals, flags and handshakes.
module tb_csa21_accum_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [20:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready, in_ready2;
    logic        out_valid, out_valid2;
    logic [20:0] out_sum, out_sum2;
    logic        out_ovf, out_ovf2;
    logic [7:0]  out_cnt;
    logic [1:0]  out_cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csa21_accum_stage #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_cnt   (out_cnt)
    );

    csa21_accum_stage #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .out_sum   (out_sum2),
        .out_ovf   (out_ovf2),
        .out_cnt   (out_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one term; returns #1 after the edge that accepts it.
    task automatic beat(input logic [20:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
    endtask

    task automatic chk_tot(input string tag, input logic [20:0] s,
                           input logic o, input logic [7:0] c);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(out_sum), 32'(s));
        chk({tag, "_ovf"}, 32'(out_ovf), 32'(o));
        chk({tag, "_cnt"}, 32'(out_cnt), 32'(c));
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);
        chk("rst_cnt", 32'(out_cnt), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Three-term packet
        beat(21'd5, 1'b0);
        beat(21'd7, 1'b0);
        chk("p3_mid_vld", 32'(out_valid), 32'd0);
        beat(21'd9, 1'b1);
        idle_in();
        chk_tot("p3", 21'd21, 1'b0, 8'd3);
        @(posedge clk);
        #1;
        chk("p3_taken_vld", 32'(out_valid), 32'd0);
        chk("p3_taken_cnt", 32'(out_cnt), 32'd0);

        // Overflow, then back-pressure
        beat(21'h1FFFFF, 1'b0);
        beat(21'h000002, 1'b1);
        idle_in();
        out_ready = 1'b0;
        chk_tot("ovf", 21'h000001, 1'b1, 8'd2);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                in_valid = 1'b1;
                in_data  = 21'd3;
                in_last  = 1'b1;
            end
            @(posedge clk);
            #1;
            chk("bp_rdy", 32'(in_ready), 32'd0);
            chk("bp_sum", 32'(out_sum), 32'h1);
            chk("bp_vld", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_rel", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        idle_in();
        chk_tot("bp_new", 21'd3, 1'b0, 8'd1);
        @(posedge clk);
        #1;
        chk("bp_taken_vld", 32'(out_valid), 32'd0);

        // Back-to-back packets; ovf must clear on the new packet
        beat(21'h1FFFFF, 1'b0);
        beat(21'd1, 1'b1);
        chk_tot("b2b_a", 21'd0, 1'b1, 8'd2);
        beat(21'd8, 1'b1);
        chk_tot("b2b_b", 21'd8, 1'b0, 8'd1);
        beat(21'd6, 1'b1);
        idle_in();
        chk_tot("b2b_c", 21'd6, 1'b0, 8'd1);
        @(posedge clk);
        #1;

        // Sticky overflow across later steps
        beat(21'h1FFFFF, 1'b0);
        beat(21'd1, 1'b0);
        beat(21'd5, 1'b1);
        idle_in();
        chk_tot("sticky", 21'd5, 1'b1, 8'd3);
        @(posedge clk);
        #1;

        // Reset mid-packet
        beat(21'd100, 1'b0);
        beat(21'd200, 1'b0);
        idle_in();
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", 32'(out_valid), 32'd0);
        chk("mrst_sum", 32'(out_sum), 32'd0);
        chk("mrst_cnt", 32'(out_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        beat(21'd10, 1'b1);
        idle_in();
        chk_tot("mrst_new", 21'd10, 1'b0, 8'd1);
        @(posedge clk);
        #1;

        // Counter saturation on the 2-bit instance
        for (int i = 0; i < 4; i++) beat(21'd1, 1'b0);
        beat(21'd1, 1'b1);
        idle_in();
        chk("sat2_vld", 32'(out_valid2), 32'd1);
        chk("sat2_sum", 32'(out_sum2), 32'd5);
        chk("sat2_cnt", 32'(out_cnt2), 32'd3);
        chk("sat2_ovf", 32'(out_ovf2), 32'd0);
        chk("sat8_cnt", 32'(out_cnt), 32'd5);
        @(posedge clk);
        #1;
        chk("sat2_taken", 32'(out_valid2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
